// File: rtl/aes_pkg.sv
// Shared Rijndael helpers: ShiftRows row offsets and byte placement for NB-column states.
package aes_pkg;

    localparam int unsigned NbAes   = 4;
    localparam int unsigned NbRijn6 = 6;
    localparam int unsigned NbRijn8 = 8;

    function automatic bit nb_legal(input int unsigned nb);
        return (nb == NbAes) || (nb == NbRijn6) || (nb == NbRijn8);
    endfunction

    // Row offset Cr; only the 8-column state spreads rows 2 and 3 further apart.
    function automatic int unsigned sr_offset(input int unsigned nb, input int unsigned row);
        if ((nb == NbRijn8) && (row >= 2)) begin
            return row + 1;
        end
        return row;
    endfunction

    // LSB of byte s[row][col] in a column-major state vector, s[0][0] in the top byte.
    function automatic int unsigned byte_lsb(input int unsigned nb, input int unsigned row,
                                             input int unsigned col);
        return 32 * nb - 8 - 8 * (4 * col + row);
    endfunction

endpackage

// File: rtl/shift_rows_stream_if.sv
// Handshake bus of the ShiftRows stream stage: producer side, consumer side and occupancy.
interface shift_rows_stream_if #(
    parameter int unsigned NB     = 4,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned FIFO_D = 2
);
    localparam int unsigned LvlW = $clog2(FIFO_D) + 1;

    logic              in_valid;
    logic              in_ready;
    logic              in_inv;
    logic [TAG_W-1:0]  in_tag;
    logic [32*NB-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [TAG_W-1:0]  out_tag;
    logic [32*NB-1:0]  out_data;
    logic [LvlW-1:0]   level;

    modport master (
        output in_valid, in_inv, in_tag, in_data, out_ready,
        input  in_ready, out_valid, out_tag, out_data, level
    );

    modport slave (
        input  in_valid, in_inv, in_tag, in_data, out_ready,
        output in_ready, out_valid, out_tag, out_data, level
    );

endinterface

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation, wired entirely at elaboration.
module shift_rows_perm
    import aes_pkg::*;
#(
    parameter int unsigned NB = 4
) (
    input  logic [32*NB-1:0] data_i,
    input  logic             inv_i,
    output logic [32*NB-1:0] data_o
);

    if (!nb_legal(NB)) begin : g_bad_nb
        $fatal(1, "shift_rows_perm: NB must be 4, 6 or 8");
    end

    logic [32*NB-1:0] fwd_data;
    logic [32*NB-1:0] inv_data;

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int unsigned Cr     = sr_offset(NB, r);
            localparam int unsigned SrcFwd = (c + Cr) % NB;
            localparam int unsigned SrcInv = (c + NB - Cr) % NB;
            localparam int unsigned DstLsb = byte_lsb(NB, r, c);
            localparam int unsigned FwdLsb = byte_lsb(NB, r, SrcFwd);
            localparam int unsigned InvLsb = byte_lsb(NB, r, SrcInv);

            assign fwd_data[DstLsb +: 8] = data_i[FwdLsb +: 8];
            assign inv_data[DstLsb +: 8] = data_i[InvLsb +: 8];
        end
    end

    assign data_o = inv_i ? inv_data : fwd_data;

endmodule

// File: rtl/shift_rows_stream.sv
// Registered ShiftRows/InvShiftRows stage with a small output FIFO and pass-through tag.
module shift_rows_stream
    import aes_pkg::*;
#(
    parameter int unsigned NB     = 4,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned FIFO_D = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    shift_rows_stream_if.slave  bus_io
);

    localparam int unsigned    W         = 32 * NB;
    localparam int unsigned    PtrW      = $clog2(FIFO_D);
    localparam int unsigned    LvlW      = $clog2(FIFO_D) + 1;
    localparam logic [LvlW-1:0] LevelFull = LvlW'(FIFO_D);

    if ((FIFO_D < 2) || ((FIFO_D & (FIFO_D - 1)) != 0)) begin : g_bad_depth
        $fatal(1, "shift_rows_stream: FIFO_D must be a power of two >= 2");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $fatal(1, "shift_rows_stream: TAG_W must be >= 1");
    end

    logic [W-1:0]     perm_data;
    logic [W-1:0]     mem_data_q [FIFO_D];
    logic [TAG_W-1:0] mem_tag_q  [FIFO_D];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]  level_q, level_d;
    logic             push;
    logic             pop;
    logic             head_valid;

    shift_rows_perm #(
        .NB (NB)
    ) u_perm (
        .data_i (bus_io.in_data),
        .inv_i  (bus_io.in_inv),
        .data_o (perm_data)
    );

    // in_ready depends on level_q alone, so a pop never opens a full FIFO in the same cycle.
    always_comb begin
        head_valid = (level_q != '0);
        push       = bus_io.in_valid && (level_q < LevelFull);
        pop        = head_valid && bus_io.out_ready;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage has no reset; the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= perm_data;
            mem_tag_q[wr_ptr_q]  <= bus_io.in_tag;
        end
    end

    assign bus_io.in_ready  = (level_q < LevelFull);
    assign bus_io.out_valid = head_valid;
    assign bus_io.out_data  = head_valid ? mem_data_q[rd_ptr_q] : '0;
    assign bus_io.out_tag   = head_valid ? mem_tag_q[rd_ptr_q] : '0;
    assign bus_io.level     = level_q;

endmodule

// File: tb/tb_shift_rows_stream.sv
// Directed and randomized checks of the ShiftRows stream stage for NB = 4, 6 and 8.
module tb_shift_rows_stream;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    shift_rows_stream_if #(.NB(4), .TAG_W(4), .FIFO_D(2)) if4 ();
    shift_rows_stream_if #(.NB(6), .TAG_W(4), .FIFO_D(2)) if6 ();
    shift_rows_stream_if #(.NB(8), .TAG_W(4), .FIFO_D(2)) if8 ();

    shift_rows_stream #(.NB(4), .TAG_W(4), .FIFO_D(2)) u_dut4 (
        .clk (clk), .rst_n (rst_n), .bus_io (if4)
    );
    shift_rows_stream #(.NB(6), .TAG_W(4), .FIFO_D(2)) u_dut6 (
        .clk (clk), .rst_n (rst_n), .bus_io (if6)
    );
    shift_rows_stream #(.NB(8), .TAG_W(4), .FIFO_D(2)) u_dut8 (
        .clk (clk), .rst_n (rst_n), .bus_io (if8)
    );

    // Reference: view the state as a 4 x nb byte matrix and rotate each row by its offset.
    function automatic logic [255:0] ref_sr(input int nb, input logic [255:0] d, input bit inv);
        int             off [4];
        logic [7:0]     s [4][8];
        logic [255:0]   o;
        int             src;
        o = '0;
        off[0] = 0;
        off[1] = 1;
        off[2] = (nb == 8) ? 3 : 2;
        off[3] = (nb == 8) ? 4 : 3;
        for (int c = 0; c < nb; c++) begin
            for (int r = 0; r < 4; r++) begin
                s[r][c] = d[32*nb-1-8*(4*c+r) -: 8];
            end
        end
        for (int c = 0; c < nb; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c - off[r] + nb) % nb : (c + off[r]) % nb;
                o[32*nb-1-8*(4*c+r) -: 8] = s[r][src];
            end
        end
        return o;
    endfunction

    function automatic logic [7:0] get_byte(input int nb, input logic [255:0] d, input int r,
                                            input int c);
        return d[32*nb-1-8*(4*c+r) -: 8];
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) begin
            v[32*i +: 32] = $urandom;
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [127:0] blk_a, blk_b, blk_c;
    logic [3:0]   tag_v;
    bit           inv_v;
    logic [255:0] d8, f8, d6, f6;

    initial begin
        if4.in_valid = 0; if4.in_inv = 0; if4.in_tag = '0; if4.in_data = '0; if4.out_ready = 0;
        if6.in_valid = 0; if6.in_inv = 0; if6.in_tag = '0; if6.in_data = '0; if6.out_ready = 1;
        if8.in_valid = 0; if8.in_inv = 0; if8.in_tag = '0; if8.in_data = '0; if8.out_ready = 1;

        // Reset state
        repeat (3) step();
        check("rst_level", if4.level, 0);
        check("rst_out_valid", if4.out_valid, 0);
        check("rst_in_ready", if4.in_ready, 1);
        check("rst_out_data", if4.out_data, 0);
        check("rst_out_tag", if4.out_tag, 0);
        rst_n = 1'b1;

        // Forward known vector, latency 1
        if4.out_ready = 1;
        if4.in_valid  = 1;
        if4.in_inv    = 0;
        if4.in_tag    = 4'h5;
        if4.in_data   = 128'h000102030405060708090a0b0c0d0e0f;
        step();
        check("fwd_valid", if4.out_valid, 1);
        check("fwd_data_const", if4.out_data, 128'h00050a0f04090e03080d02070c01060b);
        check("fwd_data_model", if4.out_data, ref_sr(4, {128'h0, 128'h000102030405060708090a0b0c0d0e0f}, 0));
        check("fwd_tag", if4.out_tag, 4'h5);

        // Inverse known vector, pushed while the previous head pops
        if4.in_inv  = 1;
        if4.in_tag  = 4'ha;
        if4.in_data = 128'h00050a0f04090e03080d02070c01060b;
        step();
        check("inv_data_const", if4.out_data, 128'h000102030405060708090a0b0c0d0e0f);
        check("inv_tag", if4.out_tag, 4'ha);
        check("inv_level", if4.level, 1);

        // Alternating fwd/inv back-to-back with push+pop every cycle at level 1
        for (int i = 0; i < 16; i++) begin
            blk_a = rand256();
            tag_v = 4'($urandom);
            inv_v = i[0];
            if4.in_inv  = inv_v;
            if4.in_tag  = tag_v;
            if4.in_data = blk_a;
            step();
            check("stream_data", if4.out_data, ref_sr(4, {128'h0, blk_a}, inv_v));
            check("stream_tag", if4.out_tag, tag_v);
            check("stream_level", if4.level, 1);
            check("stream_valid", if4.out_valid, 1);
        end
        if4.in_valid = 0;
        step();
        check("drain_level", if4.level, 0);

        // Backpressure: third block held while full, accepted the cycle after the first pop
        blk_a = rand256(); blk_b = rand256(); blk_c = rand256();
        if4.out_ready = 0;
        if4.in_inv    = 0;
        if4.in_valid  = 1;
        if4.in_tag = 4'h1; if4.in_data = blk_a; step();
        if4.in_tag = 4'h2; if4.in_data = blk_b; step();
        if4.in_tag = 4'h3; if4.in_data = blk_c; step();
        check("full_level", if4.level, 2);
        check("full_in_ready", if4.in_ready, 0);
        check("full_head", if4.out_data, ref_sr(4, {128'h0, blk_a}, 0));
        step();
        check("full_hold_level", if4.level, 2);
        check("full_hold_tag", if4.out_tag, 4'h1);
        if4.out_ready = 1;
        step();
        check("pop1_head", if4.out_data, ref_sr(4, {128'h0, blk_b}, 0));
        check("pop1_level", if4.level, 1);
        check("pop1_in_ready", if4.in_ready, 1);
        step();
        check("pop2_head", if4.out_data, ref_sr(4, {128'h0, blk_c}, 0));
        check("pop2_tag", if4.out_tag, 4'h3);
        check("pop2_level", if4.level, 1);
        if4.in_valid = 0;
        step();
        check("pop3_level", if4.level, 0);
        check("pop3_valid", if4.out_valid, 0);

        // NB=8 and NB=6: round trip and row offsets
        d8 = rand256();
        d6 = {64'h0, rand256() >> 64};
        f8 = ref_sr(8, d8, 0);
        f6 = ref_sr(6, d6, 0);
        if8.in_valid = 1; if8.in_inv = 0; if8.in_tag = 4'h7; if8.in_data = d8;
        if6.in_valid = 1; if6.in_inv = 0; if6.in_tag = 4'h9; if6.in_data = d6[191:0];
        step();
        check("nb8_fwd", if8.out_data, f8);
        check("nb8_row2_by3", get_byte(8, if8.out_data, 2, 0), get_byte(8, d8, 2, 3));
        check("nb8_row3_by4", get_byte(8, if8.out_data, 3, 0), get_byte(8, d8, 3, 4));
        check("nb8_tag", if8.out_tag, 4'h7);
        check("nb6_fwd", if6.out_data, f6);
        check("nb6_row1_by1", get_byte(6, {64'h0, if6.out_data}, 1, 5), get_byte(6, d6, 1, 0));
        check("nb6_row2_by2", get_byte(6, {64'h0, if6.out_data}, 2, 0), get_byte(6, d6, 2, 2));
        check("nb6_row3_by3", get_byte(6, {64'h0, if6.out_data}, 3, 0), get_byte(6, d6, 3, 3));
        if8.in_inv = 1; if8.in_data = f8;
        if6.in_inv = 1; if6.in_data = f6[191:0];
        step();
        check("nb8_roundtrip", if8.out_data, d8);
        check("nb6_roundtrip", if6.out_data, d6);
        if8.in_valid = 0;
        if6.in_valid = 0;
        step();
        check("nb8_drain", if8.level, 0);

        // Asynchronous reset while full
        if4.out_ready = 0;
        if4.in_valid  = 1;
        if4.in_inv    = 0;
        if4.in_data = blk_a; step();
        if4.in_data = blk_b; step();
        if4.in_valid = 0;
        check("pre_rst_level", if4.level, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", if4.out_valid, 0);
        check("async_rst_level", if4.level, 0);
        check("async_rst_in_ready", if4.in_ready, 1);
        check("async_rst_data", if4.out_data, 0);
        @(negedge clk);
        if4.in_valid  = 1;
        if4.in_inv    = 1;
        if4.in_tag    = 4'hc;
        if4.in_data   = blk_c;
        if4.out_ready = 1;
        rst_n = 1'b1;
        step();
        check("post_rst_valid", if4.out_valid, 1);
        check("post_rst_data", if4.out_data, ref_sr(4, {128'h0, blk_c}, 1));
        check("post_rst_tag", if4.out_tag, 4'hc);
        if4.in_valid = 0;
        step();
        check("post_rst_drain", if4.level, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
